// File: rtl/reg_dump_reader.sv
// reg_dump_reader
//   Walks the register bank through its combinational read port and streams
//   each register as an indexed word on a valid/ready output. Capture is
//   suspended while the core sits in a write-back state, so a word is never
//   sampled while the bank is being written.
//
//   Optional feature macro: REGDUMP_CHECKSUM_EN
//     defined   - running XOR of all dumped words, sent as one extra beat
//                 (out_sum=1, out_last=1) after index NREGS-1
//     undefined - exactly NREGS beats, out_last on index NREGS-1, out_sum=0
//
// Ports
//   clk, rst_n      clock, synchronous active-low reset
//   start           request a full dump (honoured only when idle)
//   state           core control-FSM state (write-back detection)
//   rd_addr/rd_data bank read port (index out, data in)
//   out_valid/out_ready/out_data/out_index/out_last/out_sum  output stream
//   busy            dump in progress
//   done            one-cycle pulse after the final beat is accepted
module reg_dump_reader #(
  parameter int unsigned NREGS  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32,
  parameter logic [3:0]  WB_ST0 = 4'b0110,
  parameter logic [3:0]  WB_ST1 = 4'b0111
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [3:0]        state,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              out_sum,
  output logic              busy,
  output logic              done
);

`ifdef REGDUMP_CHECKSUM_EN
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_SUM, S_DONE} fsm_t;
  localparam bit CKSUM = 1'b1;
`else
  typedef enum logic [2:0] {S_IDLE, S_READ, S_SEND, S_DONE} fsm_t;
  localparam bit CKSUM = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREGS - 1);

  fsm_t              fsm, fsm_nxt;
  logic [ADDR_W-1:0] idx;
  logic              wb_stall;
  logic              last_data;

  assign wb_stall  = (state == WB_ST0) || (state == WB_ST1);
  assign last_data = (idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (!rst_n) fsm <= S_IDLE;
    else        fsm <= fsm_nxt;
  end

  always_comb begin
    fsm_nxt   = fsm;
    out_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    rd_addr   = idx;
    case (fsm)
      S_IDLE: begin
        rd_addr = '0;
        if (start) fsm_nxt = S_READ;
      end
      S_READ: begin
        busy = 1'b1;
        if (!wb_stall) fsm_nxt = S_SEND;
      end
      S_SEND: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) begin
          if (!last_data) fsm_nxt = S_READ;
`ifdef REGDUMP_CHECKSUM_EN
          else            fsm_nxt = S_SUM;
`else
          else            fsm_nxt = S_DONE;
`endif
        end
      end
`ifdef REGDUMP_CHECKSUM_EN
      S_SUM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) fsm_nxt = S_DONE;
      end
`endif
      S_DONE: begin
        done    = 1'b1;
        fsm_nxt = S_IDLE;
      end
      default: fsm_nxt = S_IDLE;
    endcase
  end

`ifdef REGDUMP_CHECKSUM_EN
  logic [DATA_W-1:0] sum;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx       <= '0;
      out_data  <= '0;
      out_index <= '0;
      out_last  <= 1'b0;
      out_sum   <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      case (fsm)
        S_IDLE: begin
          if (start) begin
            idx     <= '0;
            out_sum <= 1'b0;
`ifdef REGDUMP_CHECKSUM_EN
            sum     <= '0;
`endif
          end
        end
        S_READ: begin
          if (!wb_stall) begin
            out_data  <= rd_data;
            out_index <= idx;
            out_last  <= last_data && !CKSUM;
`ifdef REGDUMP_CHECKSUM_EN
            sum       <= sum ^ rd_data;
`endif
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (!last_data) begin
              idx <= idx + ADDR_W'(1);
            end
`ifdef REGDUMP_CHECKSUM_EN
            else begin
              // Checksum beat is loaded straight into the output registers;
              // sum already includes the last data word captured in READ.
              out_data  <= sum;
              out_index <= '0;
              out_sum   <= 1'b1;
              out_last  <= 1'b1;
            end
`endif
          end
        end
`ifdef REGDUMP_CHECKSUM_EN
        S_SUM: begin
          if (out_ready) out_sum <= 1'b0;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_reader.sv
module tb_reg_dump_reader;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CKSUM = 1'b1;
`else
  localparam bit CKSUM = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [3:0]  state;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_index;
  logic        out_last;
  logic        out_sum;
  logic        busy;
  logic        done;

  logic [31:0] bank [32];
  logic [31:0] exp_xor;
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  assign rd_data = bank[rd_addr];

  always #5 clk = ~clk;

  reg_dump_reader #(
    .NREGS (32),
    .ADDR_W(5),
    .DATA_W(32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .state    (state),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_index(out_index),
    .out_last (out_last),
    .out_sum  (out_sum),
    .busy     (busy),
    .done     (done)
  );

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Start is sampled on the next rising edge; returns just after it.
  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    exp_xor = '0;
  endtask

  task automatic wait_beat(input int unsigned k, input logic [31:0] d);
    int unsigned n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("beat_timeout", {31'b0, out_valid}, 32'd1);
    chk("beat_index", {27'b0, out_index}, k);
    chk("beat_data", out_data, d);
    chk("beat_last", {31'b0, out_last}, {31'b0, (k == 31) && !CKSUM});
    chk("beat_sum_flag", {31'b0, out_sum}, 32'd0);
    exp_xor ^= d;
  endtask

  task automatic run_to_end(input int unsigned from);
    for (int unsigned k = from; k < 32; k++) begin
      wait_beat(k, bank[k]);
      step();
    end
    if (CKSUM) begin
      chk("sum_valid", {31'b0, out_valid}, 32'd1);
      chk("sum_flag", {31'b0, out_sum}, 32'd1);
      chk("sum_last", {31'b0, out_last}, 32'd1);
      chk("sum_index", {27'b0, out_index}, 32'd0);
      chk("sum_data", out_data, exp_xor);
      step();
    end
    chk("end_done", {31'b0, done}, 32'd1);
    chk("end_busy", {31'b0, busy}, 32'd0);
    chk("end_valid", {31'b0, out_valid}, 32'd0);
    step();
    chk("end_done_pulse", {31'b0, done}, 32'd0);
  endtask

  initial begin
    for (int unsigned i = 0; i < 32; i++) bank[i] = 32'h100 + i;
    rst_n = 1'b0; start = 1'b0; state = 4'd0; out_ready = 1'b1;
    exp_xor = '0;
    step(); step();

    // Reset state
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rd_addr", {27'b0, rd_addr}, 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_index", {27'b0, out_index}, 32'd0);
    chk("rst_last", {31'b0, out_last}, 32'd0);
    chk("rst_sum", {31'b0, out_sum}, 32'd0);
    rst_n = 1'b1;
    step();
    chk("idle_busy", {31'b0, busy}, 32'd0);

    // 1: full dump, exact 2-cycle-per-beat timing, done at t+65
    pulse_start();
    for (int unsigned k = 0; k < 32; k++) begin
      chk("t1_read_valid", {31'b0, out_valid}, 32'd0);
      chk("t1_read_busy", {31'b0, busy}, 32'd1);
      chk("t1_read_addr", {27'b0, rd_addr}, k);
      step();
      chk("t1_valid", {31'b0, out_valid}, 32'd1);
      chk("t1_index", {27'b0, out_index}, k);
      chk("t1_data", out_data, 32'h100 + k);
      chk("t1_last", {31'b0, out_last}, {31'b0, (k == 31) && !CKSUM});
      chk("t1_sum_flag", {31'b0, out_sum}, 32'd0);
      chk("t1_send_addr", {27'b0, rd_addr}, k);
      step();
    end
    if (CKSUM) begin
      chk("t1_sum_beat", {31'b0, out_sum}, 32'd1);
      chk("t1_sum_data", out_data, 32'd0);
      step();
    end
    chk("t1_done", {31'b0, done}, 32'd1);
    chk("t1_done_busy", {31'b0, busy}, 32'd0);
    chk("t1_done_addr", {27'b0, rd_addr}, 32'd31);
    step();
    chk("t1_done_once", {31'b0, done}, 32'd0);
    chk("t1_idle_addr", {27'b0, rd_addr}, 32'd0);

    // 2/3/4: backpressure on beat 3, write-back stall on index 7,
    // ignored start during beat 5
    pulse_start();
    for (int unsigned k = 0; k < 3; k++) begin
      wait_beat(k, bank[k]);
      step();
    end
    wait_beat(3, 32'h103);
    out_ready = 1'b0;
    for (int unsigned i = 0; i < 5; i++) begin
      step();
      chk("t2_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("t2_hold_data", out_data, 32'h103);
      chk("t2_hold_index", {27'b0, out_index}, 32'd3);
    end
    out_ready = 1'b1;
    step();
    wait_beat(4, 32'h104);
    step();
    wait_beat(5, 32'h105);
    start = 1'b1;
    step();
    start = 1'b0;
    wait_beat(6, 32'h106);
    step();
    // Now in READ for index 7: hold a write-back state and rewrite reg 7.
    state = 4'b0110;
    bank[7] = 32'hDEAD;
    for (int unsigned i = 0; i < 4; i++) begin
      chk("t3_stall_valid", {31'b0, out_valid}, 32'd0);
      chk("t3_stall_addr", {27'b0, rd_addr}, 32'd7);
      chk("t3_stall_busy", {31'b0, busy}, 32'd1);
      step();
    end
    state = 4'd0;
    wait_beat(7, 32'hDEAD);
    step();
    run_to_end(8);
    for (int unsigned i = 0; i < 3; i++) begin
      chk("t4_no_restart", {31'b0, busy}, 32'd0);
      chk("t4_no_2nd_done", {31'b0, done}, 32'd0);
      step();
    end
    bank[7] = 32'h107;

    // 5: reset while beat 10 is valid aborts without done
    pulse_start();
    for (int unsigned k = 0; k < 10; k++) begin
      wait_beat(k, bank[k]);
      step();
    end
    wait_beat(10, 32'h10A);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("t5_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_busy", {31'b0, busy}, 32'd0);
    chk("t5_rd_addr", {27'b0, rd_addr}, 32'd0);
    chk("t5_done", {31'b0, done}, 32'd0);
    step();
    chk("t5_done_later", {31'b0, done}, 32'd0);
    pulse_start();
    wait_beat(0, 32'h100);
    step();
    run_to_end(1);

    // 6: one-hot bank; checksum beat (if built in) is all ones
    for (int unsigned i = 0; i < 32; i++) bank[i] = 32'd1 << i;
    pulse_start();
    run_to_end(0);
    if (CKSUM) chk("t6_xor_all_ones", exp_xor, 32'hFFFFFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
